// File: rtl/if_id_skid_stage.sv
// ---------------------------------------------------------------------------
// if_id_skid_stage
//
// IF/ID pipeline register with a valid/ready handshake on both sides.
// Holds up to two fetched words (SKID=1: main + skid entry, registered
// In_Ready) or one word (SKID=0: main only, combinational In_Ready). Each entry
// carries the instruction, PC+4, the branch flag and the branch offset
// extended to ADDR_W at load time. Flush/i_flush empty the stage, clear the
// instruction and branch flag, and keep PC+4 and branch address. i_enable=0
// masks both handshakes and freezes all state.
//
// Ports
//   Clock, Reset        rising-edge clock, asynchronous active-high reset
//   In_Valid/In_Ready   fetch-side handshake
//   In_Instruction      fetched word; [IMM_W-1:0] is the branch offset
//   In_PCAdder          PC+4 from fetch
//   In_Branch           branch flag from fetch
//   Flush, i_flush      hazard flush / debug flush (highest priority)
//   i_enable            debug step enable, 0 freezes the stage
//   Out_Valid/Out_Ready decode-side handshake
//   Out_Instruction     registered instruction
//   Out_PCAdder         registered PC+4
//   Out_BranchAddress   registered extended branch offset
//   Out_Branch          registered branch flag
// ---------------------------------------------------------------------------
module if_id_skid_stage #(
  parameter int INSTR_W  = 32,
  parameter int ADDR_W   = 32,
  parameter int IMM_W    = 16,
  parameter int SIGN_EXT = 0,
  parameter int SKID     = 1
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               In_Valid,
  output logic               In_Ready,
  input  logic [INSTR_W-1:0] In_Instruction,
  input  logic [ADDR_W-1:0]  In_PCAdder,
  input  logic               In_Branch,
  input  logic               Flush,
  input  logic               i_enable,
  input  logic               i_flush,
  output logic               Out_Valid,
  input  logic               Out_Ready,
  output logic [INSTR_W-1:0] Out_Instruction,
  output logic [ADDR_W-1:0]  Out_PCAdder,
  output logic [ADDR_W-1:0]  Out_BranchAddress,
  output logic               Out_Branch
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_adder;
    logic [ADDR_W-1:0]  branch_addr;
    logic               branch;
  } entry_t;

  state_e            state_q, state_d;
  entry_t            main_q, main_d;
  entry_t            skid_q, skid_d;
  logic              in_ready_q, in_ready_d;

  logic              flush_any;
  logic              out_valid_int;
  logic              in_ready_pre;
  logic              in_hs;
  logic              out_hs;
  logic [ADDR_W-1:0] branch_addr_in;
  entry_t            in_entry;

  // Branch offset extension, done once when the word enters the stage.
  generate
    if (ADDR_W > IMM_W) begin : g_ext
      logic ext_bit;
      assign ext_bit        = (SIGN_EXT != 0) ? In_Instruction[IMM_W-1] : 1'b0;
      assign branch_addr_in = {{(ADDR_W-IMM_W){ext_bit}}, In_Instruction[IMM_W-1:0]};
    end else begin : g_noext
      assign branch_addr_in = In_Instruction[IMM_W-1:0];
    end
  endgenerate

  // Handshake qualification. With SKID=1 the ready is a flop so fetch never
  // sees a combinational path from Out_Ready; with SKID=0 a word can only be
  // taken when the single slot is empty or draining this cycle.
  always_comb begin
    flush_any     = Flush | i_flush;
    out_valid_int = (state_q != ST_EMPTY);
    in_ready_pre  = (SKID != 0) ? in_ready_q : (~out_valid_int | Out_Ready);
  end

  assign In_Ready  = in_ready_pre & i_enable;
  assign Out_Valid = out_valid_int & i_enable;
  assign in_hs     = In_Valid & In_Ready;
  assign out_hs    = Out_Valid & Out_Ready;

  always_comb begin
    in_entry.instr       = In_Instruction;
    in_entry.pc_adder    = In_PCAdder;
    in_entry.branch_addr = branch_addr_in;
    in_entry.branch      = In_Branch;
  end

  // Next-state and datapath selection.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush_any) begin
      // Flush wins over any handshake; the skid entry is simply abandoned and
      // PC+4 / branch address are deliberately left as they were.
      state_d       = ST_EMPTY;
      main_d.instr  = '0;
      main_d.branch = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_hs) begin
            main_d  = in_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_hs && out_hs) begin
            main_d = in_entry;
          end else if (in_hs) begin
            // Only reachable with SKID=1: decode stalled, park the word.
            if (SKID != 0) begin
              skid_d  = in_entry;
              state_d = ST_FULL;
            end
          end else if (out_hs) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_hs) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    in_ready_d = (state_d != ST_FULL);
  end

  // NOTE: the two entries are only a few flops, so they are reset along with
  // the control state; outputs then read a defined 0 straight out of reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign Out_Instruction   = main_q.instr;
  assign Out_PCAdder       = main_q.pc_adder;
  assign Out_BranchAddress = main_q.branch_addr;
  assign Out_Branch        = main_q.branch;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// ---------------------------------------------------------------------------
// tb_if_id_skid_stage
//
// Two instances share one stimulus stream:
//   dut_a : SKID=1, SIGN_EXT=1
//   dut_b : SKID=0, SIGN_EXT=0
// A FIFO-level model per instance predicts every output each cycle; directed
// literal expectations pin the model at the interesting points.
// ---------------------------------------------------------------------------
module tb_if_id_skid_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        in_branch;
  logic        flush;
  logic        en;
  logic        dflush;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_branch;
  logic [31:0] a_out_instr, a_out_pc, a_out_ba;
  logic        b_in_ready, b_out_valid, b_out_branch;
  logic [31:0] b_out_instr, b_out_pc, b_out_ba;

  int n_checks = 0;
  int n_fail   = 0;

  if_id_skid_stage #(
    .INSTR_W(32), .ADDR_W(32), .IMM_W(16), .SIGN_EXT(1), .SKID(1)
  ) dut_a (
    .Clock(clk), .Reset(rst),
    .In_Valid(in_valid), .In_Ready(a_in_ready),
    .In_Instruction(in_instr), .In_PCAdder(in_pc), .In_Branch(in_branch),
    .Flush(flush), .i_enable(en), .i_flush(dflush),
    .Out_Valid(a_out_valid), .Out_Ready(out_ready),
    .Out_Instruction(a_out_instr), .Out_PCAdder(a_out_pc),
    .Out_BranchAddress(a_out_ba), .Out_Branch(a_out_branch)
  );

  if_id_skid_stage #(
    .INSTR_W(32), .ADDR_W(32), .IMM_W(16), .SIGN_EXT(0), .SKID(0)
  ) dut_b (
    .Clock(clk), .Reset(rst),
    .In_Valid(in_valid), .In_Ready(b_in_ready),
    .In_Instruction(in_instr), .In_PCAdder(in_pc), .In_Branch(in_branch),
    .Flush(flush), .i_enable(en), .i_flush(dflush),
    .Out_Valid(b_out_valid), .Out_Ready(out_ready),
    .Out_Instruction(b_out_instr), .Out_PCAdder(b_out_pc),
    .Out_BranchAddress(b_out_ba), .Out_Branch(b_out_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] ba;
    logic        br;
  } ent_t;

  ent_t fifo [2][2];   // per instance, index 0 is the oldest word
  ent_t disp [2];      // what the output registers must show
  int   cnt  [2];
  bit   rdy_ok [2];    // registered ready has seen an edge since reset
  bit   m_ih, m_oh;
  ent_t m_e;

  function automatic bit m_ready(input int k);
    if (k == 0) return en && rdy_ok[0] && (cnt[0] < 2);
    else        return en && ((cnt[1] == 0) || out_ready);
  endfunction

  function automatic bit m_valid(input int k);
    return en && (cnt[k] > 0);
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      m_ih     = in_valid && m_ready(k);
      m_oh     = m_valid(k) && out_ready;
      m_e.instr = in_instr;
      m_e.pc    = in_pc;
      m_e.br    = in_branch;
      if (k == 0) m_e.ba = 32'($signed(in_instr[15:0]));
      else        m_e.ba = {16'h0000, in_instr[15:0]};
      if (flush || dflush) begin
        cnt[k]        = 0;
        disp[k].instr = '0;
        disp[k].br    = 1'b0;
      end else begin
        if (m_oh) begin
          fifo[k][0] = fifo[k][1];
          cnt[k]     = cnt[k] - 1;
        end
        if (m_ih) begin
          fifo[k][cnt[k]] = m_e;
          cnt[k]          = cnt[k] + 1;
        end
        if (cnt[k] > 0) disp[k] = fifo[k][0];
      end
      rdy_ok[k] = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int k = 0; k < 2; k++) begin
          cnt[k]    = 0;
          disp[k]   = '0;
          rdy_ok[k] = 1'b0;
        end
      end else begin
        model_step();
      end
    end
  end

  // ---------------------------------------------------------------- checking
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string p, input int k, input logic rdy, input logic vld,
                     input logic [31:0] ins, input logic [31:0] pc,
                     input logic [31:0] ba, input logic br);
    check({p, "_in_ready"},  {31'd0, rdy}, {31'd0, m_ready(k)});
    check({p, "_out_valid"}, {31'd0, vld}, {31'd0, m_valid(k)});
    check({p, "_out_instr"}, ins, disp[k].instr);
    check({p, "_out_pc"},    pc,  disp[k].pc);
    check({p, "_out_ba"},    ba,  disp[k].ba);
    check({p, "_out_br"},    {31'd0, br}, {31'd0, disp[k].br});
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cmp("a", 0, a_in_ready, a_out_valid, a_out_instr, a_out_pc, a_out_ba, a_out_branch);
      cmp("b", 1, b_in_ready, b_out_valid, b_out_instr, b_out_pc, b_out_ba, b_out_branch);
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic br);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    in_branch = br;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    dflush    = 1'b0;
    en        = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("rst_out_instr", a_out_instr, 32'd0);
    check("rst_out_pc",    a_out_pc,    32'd0);
    rst = 1'b0;
    cyc();
    check("post_rst_in_ready", {31'd0, a_in_ready}, 32'd1);

    // Streaming 1..8 with Out_Ready=1: one word per cycle, one cycle latency
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i), 32'(i * 4), i[0]);
      check($sformatf("stream_ready_%0d", i), {31'd0, a_in_ready}, 32'd1);
      cyc();
      check($sformatf("stream_valid_%0d", i), {31'd0, a_out_valid}, 32'd1);
      check($sformatf("stream_instr_%0d", i), a_out_instr, 32'(i));
      check($sformatf("stream_pc_%0d", i),    a_out_pc,    32'(i * 4));
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    cyc();
    check("stream_drained", {31'd0, a_out_valid}, 32'd0);
    cyc();

    // Back-pressure on the skid instance: 0xA, 0xB fit, 0xC waits
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_000A, 32'h0000_0010, 1'b0);
    cyc();
    drive(1'b1, 32'h0000_000B, 32'h0000_0014, 1'b0);
    cyc();
    drive(1'b1, 32'h0000_000C, 32'h0000_0018, 1'b0);
    check("bp_full_ready", {31'd0, a_in_ready}, 32'd0);
    check("bp_head_a",     a_out_instr, 32'h0000_000A);
    repeat (2) begin
      cyc();
      check("bp_hold_ready", {31'd0, a_in_ready}, 32'd0);
      check("bp_hold_instr", a_out_instr, 32'h0000_000A);
    end
    out_ready = 1'b1;
    cyc();
    check("bp_head_b",      a_out_instr, 32'h0000_000B);
    check("bp_ready_back",  {31'd0, a_in_ready}, 32'd1);
    cyc();
    check("bp_head_c",      a_out_instr, 32'h0000_000C);
    check("bp_head_c_pc",   a_out_pc,    32'h0000_0018);
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) cyc();

    // Branch offset extension
    drive(1'b1, 32'h1000_FFFC, 32'h0000_0300, 1'b1);
    cyc();
    check("sext_ba", a_out_ba, 32'hFFFF_FFFC);
    check("zext_ba", b_out_ba, 32'h0000_FFFC);
    check("ext_br",  {31'd0, a_out_branch}, 32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) cyc();

    // Flush while FULL, with a word offered in the same cycle
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0011, 32'h0000_0044, 1'b1);
    cyc();
    drive(1'b1, 32'h0000_0022, 32'h0000_0048, 1'b1);
    cyc();
    check("fl_full_ready", {31'd0, a_in_ready}, 32'd0);
    flush = 1'b1;
    drive(1'b1, 32'h0000_0033, 32'h0000_004C, 1'b1);
    cyc();
    flush = 1'b0;
    check("fl_valid", {31'd0, a_out_valid},  32'd0);
    check("fl_instr", a_out_instr,           32'd0);
    check("fl_br",    {31'd0, a_out_branch}, 32'd0);
    check("fl_pc",    a_out_pc,              32'h0000_0044);
    check("fl_ba",    a_out_ba,              32'h0000_0011);
    check("fl_ready", {31'd0, a_in_ready},   32'd1);
    // Debug flush drops a handshake that would otherwise fire
    dflush = 1'b1;
    drive(1'b1, 32'h0000_0055, 32'h0000_0050, 1'b1);
    cyc();
    dflush = 1'b0;
    check("dfl_valid", {31'd0, a_out_valid}, 32'd0);
    check("dfl_pc",    a_out_pc,             32'h0000_0044);
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    out_ready = 1'b1;
    cyc();
    check("fl_nothing_left", {31'd0, a_out_valid}, 32'd0);
    cyc();

    // i_enable low while FULL and decode ready: everything frozen
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0061, 32'h0000_0100, 1'b0);
    cyc();
    drive(1'b1, 32'h0000_0062, 32'h0000_0104, 1'b1);
    cyc();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    en        = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check($sformatf("en_ready_%0d", i), {31'd0, a_in_ready},  32'd0);
      check($sformatf("en_valid_%0d", i), {31'd0, a_out_valid}, 32'd0);
      check($sformatf("en_instr_%0d", i), a_out_instr,          32'h0000_0061);
    end
    en = 1'b1;
    #1;
    check("en_resume_valid", {31'd0, a_out_valid}, 32'd1);
    check("en_resume_head",  a_out_instr,          32'h0000_0061);
    cyc();
    check("en_resume_next",  a_out_instr,          32'h0000_0062);
    check("en_resume_pc",    a_out_pc,             32'h0000_0104);
    cyc();
    check("en_drained", {31'd0, a_out_valid}, 32'd0);

    // Asynchronous reset between edges while holding one word
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0077, 32'h0000_0200, 1'b1);
    cyc();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("ar_before_valid", {31'd0, a_out_valid}, 32'd1);
    check("ar_before_instr", a_out_instr,          32'h0000_0077);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", {31'd0, a_out_valid},  32'd0);
    check("ar_instr", a_out_instr,           32'd0);
    check("ar_pc",    a_out_pc,              32'd0);
    check("ar_ba",    a_out_ba,              32'd0);
    check("ar_br",    {31'd0, a_out_branch}, 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    cyc();
    check("ar_ready_back", {31'd0, a_in_ready}, 32'd1);
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
